// File: rtl/multicycle_pc_sequencer.sv
// multicycle_pc_sequencer: main control FSM of the multicycle MIPS core.
// Sequences fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_pc_sequencer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [5:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [3:0]           state,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] retired_count
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    state_t cur, nxt;
    logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, retire;

    assign is_r    = opcode == 6'b000000;
    assign is_addi = opcode == 6'b001000;
    assign is_lw   = opcode == 6'b100011;
    assign is_sw   = opcode == 6'b101011;
    assign is_beq  = opcode == 6'b000100;
    assign is_bne  = opcode == 6'b000101;
    assign is_j    = opcode == 6'b000010;
    assign is_jal  = opcode == 6'b000011;

    assign retire = cur == S_MEMWB || cur == S_ALUWB || cur == S_BRANCH ||
                    cur == S_JUMP || (cur == S_MEMWR && mem_ready);

    assign state = cur;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cur <= S_FETCH;
        else          cur <= nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    retired_count <= '0;
        else if (retire) retired_count <= retired_count + 1'b1;
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = (run && mem_ready) ? S_DECODE : S_FETCH;
            S_DECODE: nxt = (is_lw || is_sw)    ? S_MEMADR :
                            (is_r || is_addi)   ? S_EXEC   :
                            (is_beq || is_bne)  ? S_BRANCH :
                            (is_j || is_jal)    ? S_JUMP   : S_FETCH;
            S_MEMADR: nxt = is_lw ? S_MEMRD : is_sw ? S_MEMWR : S_FETCH;
            S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_ALUWB;
            default:  nxt = S_FETCH;
        endcase
    end

    // Everything is forced low while reset_n is asserted, even though state already reads S_FETCH.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        if (reset_n) begin
            case (cur)
                S_FETCH: begin
                    mem_read  = run;
                    alu_src_b = run ? 2'b01 : 2'b00;
                    ir_write  = run && mem_ready;
                    pc_write  = run && mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = !(is_r || is_addi || is_lw || is_sw ||
                                   is_beq || is_bne || is_j || is_jal);
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = is_r ? 2'b00 : 2'b10;
                    alu_op    = is_r ? 2'b10 : 2'b00;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = is_r ? 2'b01 : 2'b00;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    pc_write  = (is_beq && zero) || (is_bne && !zero);
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    reg_write  = is_jal;
                    reg_dst    = is_jal ? 2'b10 : 2'b00;
                    mem_to_reg = is_jal ? 2'b10 : 2'b00;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_pc_sequencer.sv
// tb_multicycle_pc_sequencer: randomized self-checking bench; the model derives each
// instruction's state walk, strobe counts and retire count from the opcode rules.
module tb_multicycle_pc_sequencer;
    localparam int W = 4;

    logic clock = 1'b0, reset_n = 1'b0, run = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic [3:0] state;
    logic [W-1:0] retired_count;
    logic [25:0] allout;

    int checks = 0, failures = 0, model = 0;

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                           OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                           OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;

    multicycle_pc_sequencer #(.CNT_WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .illegal_op(illegal_op), .retired_count(retired_count)
    );

    assign allout = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
                     reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, state,
                     illegal_op, retired_count};

    always #5 clock = ~clock;

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        model = 0;
    endtask

    // Runs one instruction; w = memory wait cycles, fw = fetch wait cycles.
    task automatic exec_instr(input logic [5:0] op, input logic z, input int w, input int fw);
        int exp_st[$];
        int n_pcw = 0, n_rw = 0, exp_pcw, exp_rw, st;
        bit lw, sw, r, addi, br, jmp, jal, ill, taken;
        lw = op == OP_LW; sw = op == OP_SW; r = op == OP_R; addi = op == OP_ADDI;
        br = op == OP_BEQ || op == OP_BNE; jal = op == OP_JAL; jmp = op == OP_J || jal;
        ill = !(lw || sw || r || addi || br || jmp);
        taken = (op == OP_BEQ && z) || (op == OP_BNE && !z);
        for (int k = 0; k <= fw; k++) exp_st.push_back(0);
        exp_st.push_back(1);
        if (lw || sw) exp_st.push_back(2);
        for (int k = 0; k <= w; k++) if (lw) exp_st.push_back(3); else if (sw) exp_st.push_back(5);
        if (lw) exp_st.push_back(4);
        if (r || addi) begin exp_st.push_back(6); exp_st.push_back(7); end
        if (br) exp_st.push_back(8);
        if (jmp) exp_st.push_back(9);
        exp_pcw = 1 + ((taken || jmp) ? 1 : 0);
        exp_rw = (lw || r || addi || jal) ? 1 : 0;
        for (int i = 0; i < exp_st.size(); i++) begin
            st = exp_st[i];
            run = 1'b1;
            opcode = (st == 0) ? 6'($urandom) : op;
            zero = (st == 8) ? z : 1'($urandom);
            mem_ready = (st == 0 || st == 3 || st == 5) ?
                        (i + 1 == exp_st.size() || exp_st[i+1] != st) : 1'($urandom);
            #1;
            checks++;
            if (state !== 4'(st)) begin
                failures++;
                $display("FAIL state op=%b cyc=%0d got=%0d want=%0d", op, i, state, st);
            end
            checks++;
            if (mem_read && mem_write) begin
                failures++;
                $display("FAIL rd_wr_excl op=%b cyc=%0d got both=1 want not both", op, i);
            end
            n_pcw += pc_write;
            n_rw += reg_write;
            if (st == 0) begin
                checks++;
                if ({mem_read, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op} !==
                    {1'b1, 1'b0, mem_ready, mem_ready, 2'b00, 1'b0, 2'b01, 2'b00}) begin
                    failures++;
                    $display("FAIL fetch_ctl op=%b got=%b rdy=%b", op,
                        {mem_read, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op}, mem_ready);
                end
            end else if (st == 1) begin
                checks++;
                if ({illegal_op, alu_src_a, alu_src_b, alu_op} !== {ill, 1'b0, 2'b11, 2'b00}) begin
                    failures++;
                    $display("FAIL decode_ctl op=%b got=%b want ill=%b src_b=11",
                        op, {illegal_op, alu_src_a, alu_src_b, alu_op}, ill);
                end
            end else if (st == 2) begin
                checks++;
                if ({alu_src_a, alu_src_b, alu_op} !== 5'b1_10_00) begin
                    failures++;
                    $display("FAIL memadr_ctl got=%b want=11000", {alu_src_a, alu_src_b, alu_op});
                end
            end else if (st == 3 || st == 5) begin
                checks++;
                if ({mem_read, mem_write, iord} !== {st == 3, st == 5, 1'b1}) begin
                    failures++;
                    $display("FAIL mem_access st=%0d got=%b", st, {mem_read, mem_write, iord});
                end
            end else if (st == 4) begin
                checks++;
                if ({reg_write, reg_dst, mem_to_reg} !== 5'b1_00_01) begin
                    failures++;
                    $display("FAIL memwb_ctl got=%b want=10001", {reg_write, reg_dst, mem_to_reg});
                end
            end else if (st == 6) begin
                checks++;
                if ({alu_src_a, alu_src_b, alu_op} !== {1'b1, r ? 4'b0010 : 4'b1000}) begin
                    failures++;
                    $display("FAIL exec_ctl op=%b got=%b", op, {alu_src_a, alu_src_b, alu_op});
                end
            end else if (st == 7) begin
                checks++;
                if ({reg_write, reg_dst, mem_to_reg} !== {1'b1, r ? 2'b01 : 2'b00, 2'b00}) begin
                    failures++;
                    $display("FAIL aluwb_ctl op=%b got=%b", op, {reg_write, reg_dst, mem_to_reg});
                end
            end else if (st == 8) begin
                checks++;
                if ({pc_write, pc_src, alu_src_a, alu_src_b, alu_op} !== {taken, 2'b01, 1'b1, 2'b00, 2'b01}) begin
                    failures++;
                    $display("FAIL branch_ctl op=%b z=%b got=%b want pcw=%b", op, z,
                        {pc_write, pc_src, alu_src_a, alu_src_b, alu_op}, taken);
                end
            end else if (st == 9) begin
                checks++;
                if ({pc_write, pc_src, reg_write, reg_dst, mem_to_reg} !==
                    {1'b1, 2'b10, jal, jal ? 4'b1010 : 4'b0000}) begin
                    failures++;
                    $display("FAIL jump_ctl op=%b got=%b", op, {pc_write, pc_src, reg_write, reg_dst, mem_to_reg});
                end
            end
            @(posedge clock);
            #1;
        end
        if (!ill) model = (model + 1) % (1 << W);
        run = 1'b0;
        #1;
        checks++;
        if ({n_pcw, n_rw} !== {exp_pcw, exp_rw}) begin
            failures++;
            $display("FAIL strobes op=%b got pcw=%0d rw=%0d want pcw=%0d rw=%0d", op, n_pcw, n_rw, exp_pcw, exp_rw);
        end
        checks++;
        if ({state, retired_count} !== {4'd0, W'(model)}) begin
            failures++;
            $display("FAIL end_state op=%b got st=%0d cnt=%0d want st=0 cnt=%0d", op, state, retired_count, model);
        end
    endtask

    task automatic test_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = OP_LW;
        reset_n = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #2;
            checks++;
            if (allout !== '0) begin
                failures++;
                $display("FAIL reset_outputs got=%b want=0", allout);
            end
        end
        run = 1'b0;
        reset_n = 1'b1;
        model = 0;
        repeat (5) begin
            mem_ready = 1'($urandom);
            @(posedge clock);
            #2;
            checks++;
            if (allout !== '0) begin
                failures++;
                $display("FAIL idle_outputs got=%b want=0", allout);
            end
        end
        run = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if ({pc_write, ir_write} !== 2'b11) begin
            failures++;
            $display("FAIL first_fetch got=%b want=11", {pc_write, ir_write});
        end
        @(posedge clock);
        #1;
        checks++;
        if (state !== 4'd1) begin
            failures++;
            $display("FAIL first_decode got=%0d want=1", state);
        end
        run = 1'b0;
        do_reset();
    endtask

    task automatic test_lw_wait();
        exec_instr(OP_LW, 1'b0, 2, 0);
    endtask

    task automatic test_branch();
        exec_instr(OP_BEQ, 1'b1, 0, 0);
        exec_instr(OP_BEQ, 1'b0, 0, 0);
        exec_instr(OP_BNE, 1'b0, 0, 0);
        exec_instr(OP_BNE, 1'b1, 0, 1);
    endtask

    task automatic test_jal_rtype();
        exec_instr(OP_JAL, 1'b0, 0, 0);
        exec_instr(OP_R, 1'b0, 0, 0);
        exec_instr(OP_ADDI, 1'b1, 0, 0);
        exec_instr(OP_J, 1'b1, 0, 0);
    endtask

    task automatic test_illegal();
        exec_instr(OP_BAD, 1'b0, 0, 0);
        exec_instr(6'b011010, 1'b1, 0, 0);
    endtask

    task automatic test_abort();
        exec_instr(OP_ADDI, 1'b0, 0, 0);
        run = 1'b1; mem_ready = 1'b1; opcode = OP_SW;
        repeat (3) @(posedge clock);
        #1 mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, mem_write} !== {4'd5, 1'b1}) begin
            failures++;
            $display("FAIL abort_setup got st=%0d mw=%b want st=5 mw=1", state, mem_write);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_write, state, retired_count, pc_write, reg_write} !== '0) begin
            failures++;
            $display("FAIL abort_reset got mw=%b st=%0d cnt=%0d want 0", mem_write, state, retired_count);
        end
        run = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        model = 0;
    endtask

    task automatic test_random();
        logic [5:0] ops [9];
        ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_BAD};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(3) == 0) begin
                run = 1'b0; mem_ready = 1'($urandom); opcode = 6'($urandom);
                #1;
                checks++;
                if (allout !== {22'd0, W'(model)}) begin
                    failures++;
                    $display("FAIL idle_rand got=%b cnt_want=%0d", allout, model);
                end
                @(posedge clock);
                #1;
            end
            exec_instr(ops[$urandom_range(8)], 1'($urandom), $urandom_range(3), $urandom_range(2));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 1; n <= 17; n++) exec_instr(OP_R, 1'($urandom), 0, 0);
        checks++;
        if (retired_count !== 4'd1) begin
            failures++;
            $display("FAIL wrap got=%0d want=1", retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_branch();
        test_jal_rtype();
        test_illegal();
        test_abort();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
